// File: rtl/bicubic_core.sv
// -----------------------------------------------------------------------------
// bicubic_core
// Separable 2-D interpolation engine (Keys a=-0.5 bicubic, bilinear, nearest).
// Accepts a 4x4 window one row per handshake, produces one pixel per window
// over a valid/ready output, and pulses o_done after every N_PIX outputs.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   row beat valid
//   o_in_ready   engine accepts a row beat (LOAD state only)
//   i_in_row     pixels p0..p3, p0 in the LSBs
//   i_in_fx/fy   horizontal/vertical phase, sampled on the row-0 beat
//   i_in_mode    00 bicubic, 01 bilinear, 10 nearest, 11 bicubic
//   o_out_valid  o_out_val valid
//   i_out_ready  consumer accepts o_out_val
//   o_out_val    interpolated pixel
//   o_done       one-cycle pulse after the last output of a frame
// -----------------------------------------------------------------------------
module bicubic_core #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned FRAC_W = 4,
   parameter int unsigned N_PIX  = 16
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_in_valid,
   output logic                o_in_ready,
   input  logic [4*DATA_W-1:0] i_in_row,
   input  logic [FRAC_W-1:0]   i_in_fx,
   input  logic [FRAC_W-1:0]   i_in_fy,
   input  logic [1:0]          i_in_mode,
   output logic                o_out_valid,
   input  logic                i_out_ready,
   output logic [DATA_W-1:0]   o_out_val,
   output logic                o_done
);

   // WC: headroom for weight intermediates (|3T^3|, |5T^2 S| < 2^(3F+3)).
   localparam int unsigned WC    = 3*FRAC_W + 6;
   localparam int unsigned WW    = 3*FRAC_W + 3;
   localparam int unsigned HW    = DATA_W + 3*FRAC_W + 3;
   localparam int unsigned AW    = DATA_W + 6*FRAC_W + 6;
   localparam int unsigned K     = 6*FRAC_W + 2;
   localparam int unsigned CNT_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
   localparam logic signed [AW-1:0] RND = AW'(1) <<< (K-1);

   typedef enum logic [1:0] {S_LOAD, S_CALC, S_OUT} state_t;

   // Integer tap weight (scale 2*S^3) for tap idx at phase f in the given mode.
   function automatic logic signed [WW-1:0] f_weight(input logic [1:0]        idx,
                                                     input logic [FRAC_W-1:0] f,
                                                     input logic [1:0]        mode);
      logic signed [WC-1:0] t, s, t2, t3, s2, s3, w;
      t  = WC'(f);
      s  = WC'(1) <<< FRAC_W;
      t2 = t * t;
      t3 = t2 * t;
      s2 = s * s;
      s3 = s2 * s;
      w  = '0;
      case (mode)
         2'b01: begin
            if (idx == 2'd1)      w = (s2 + s2) * (s - t);
            else if (idx == 2'd2) w = (s2 + s2) * t;
         end
         2'b10: begin
            // Phase below one half picks p1, otherwise p2.
            if ((idx == 2'd1 && t < (s >>> 1)) || (idx == 2'd2 && t >= (s >>> 1)))
               w = s3 + s3;
         end
         default: begin
            case (idx)
               2'd0:    w = -t3 + WC'(2) * t2 * s - t * s2;
               2'd1:    w = WC'(3) * t3 - WC'(5) * t2 * s + WC'(2) * s3;
               2'd2:    w = -(WC'(3) * t3) + WC'(4) * t2 * s + t * s2;
               default: w = t3 - t2 * s;
            endcase
         end
      endcase
      return WW'(w);
   endfunction

   state_t                r_state, w_state_nxt;
   logic [1:0]            r_row, w_row_nxt;
   logic [FRAC_W-1:0]     r_fx, w_fx_nxt, r_fy, w_fy_nxt;
   logic [1:0]            r_mode, w_mode_nxt;
   logic signed [HW-1:0]  r_h [4];
   logic signed [HW-1:0]  w_h_nxt [4];
   logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
   logic                  r_out_valid, w_out_valid_nxt;
   logic [DATA_W-1:0]     r_out_val, w_out_val_nxt;
   logic                  r_done, w_done_nxt;
   logic                  r_in_ready, w_in_ready_nxt;

   logic [FRAC_W-1:0]     w_fx;
   logic [1:0]            w_hmode;
   logic signed [WW-1:0]  w_wx [4];
   logic signed [WW-1:0]  w_wy [4];
   logic signed [HW-1:0]  w_hsum;
   logic signed [AW-1:0]  w_acc;
   logic signed [AW-1:0]  w_res;
   logic [DATA_W-1:0]     w_pix;

   // Horizontal sum of the incoming row; row 0 uses its own phase/mode live.
   always_comb begin : horiz
      w_fx    = (r_row == 2'd0) ? i_in_fx   : r_fx;
      w_hmode = (r_row == 2'd0) ? i_in_mode : r_mode;
      w_hsum  = '0;
      for (int i = 0; i < 4; i++) begin
         w_wx[i] = f_weight(2'(i), w_fx, w_hmode);
         w_hsum  = w_hsum + HW'(w_wx[i]) * HW'($signed({1'b0, i_in_row[i*DATA_W +: DATA_W]}));
      end
   end

   // Vertical sum, round half up, clamp to the pixel range.
   always_comb begin : vert
      w_acc = '0;
      for (int j = 0; j < 4; j++) begin
         w_wy[j] = f_weight(2'(j), r_fy, r_mode);
         w_acc   = w_acc + AW'(w_wy[j]) * AW'(r_h[j]);
      end
      w_res = (w_acc + RND) >>> K;
      if (w_res[AW-1])
         w_pix = '0;
      else if (|w_res[AW-2:DATA_W])
         w_pix = '1;
      else
         w_pix = w_res[DATA_W-1:0];
   end

   // Next-state and registered-output logic.
   always_comb begin : fsm_comb
      w_state_nxt     = r_state;
      w_row_nxt       = r_row;
      w_fx_nxt        = r_fx;
      w_fy_nxt        = r_fy;
      w_mode_nxt      = r_mode;
      w_h_nxt         = r_h;
      w_cnt_nxt       = r_cnt;
      w_out_valid_nxt = r_out_valid;
      w_out_val_nxt   = r_out_val;
      w_done_nxt      = 1'b0;
      case (r_state)
         S_LOAD: begin
            if (i_in_valid && r_in_ready) begin
               w_h_nxt[r_row] = w_hsum;
               if (r_row == 2'd0) begin
                  w_fx_nxt   = i_in_fx;
                  w_fy_nxt   = i_in_fy;
                  w_mode_nxt = i_in_mode;
               end
               w_row_nxt = r_row + 2'd1;
               if (r_row == 2'd3) w_state_nxt = S_CALC;
            end
         end
         S_CALC: begin
            w_out_valid_nxt = 1'b1;
            w_out_val_nxt   = w_pix;
            w_state_nxt     = S_OUT;
         end
         S_OUT: begin
            if (i_out_ready) begin
               w_out_valid_nxt = 1'b0;
               w_row_nxt       = '0;
               w_state_nxt     = S_LOAD;
               if (r_cnt == CNT_W'(N_PIX - 1)) begin
                  w_cnt_nxt  = '0;
                  w_done_nxt = 1'b1;
               end else begin
                  w_cnt_nxt  = r_cnt + CNT_W'(1);
               end
            end
         end
         default: w_state_nxt = S_LOAD;
      endcase
      w_in_ready_nxt = (w_state_nxt == S_LOAD);
   end

   // State and datapath registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_LOAD;
         r_row       <= '0;
         r_fx        <= '0;
         r_fy        <= '0;
         r_mode      <= '0;
         for (int i = 0; i < 4; i++) r_h[i] <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_val   <= '0;
         r_done      <= 1'b0;
         r_in_ready  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_row       <= w_row_nxt;
         r_fx        <= w_fx_nxt;
         r_fy        <= w_fy_nxt;
         r_mode      <= w_mode_nxt;
         for (int i = 0; i < 4; i++) r_h[i] <= w_h_nxt[i];
         r_cnt       <= w_cnt_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_val   <= w_out_val_nxt;
         r_done      <= w_done_nxt;
         r_in_ready  <= w_in_ready_nxt;
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_out_val   = r_out_val;
   assign o_done      = r_done;

endmodule

// File: doc/bicubic_core.md
# bicubic_core

Parametrised 2-D bicubic interpolation engine: the successor to the fixed single-pixel `Bicubic` block. It accepts a 4x4 source window one row per handshake, with fractional phases fx/fy and a run-time interpolation mode. It computes one interpolated pixel per window through a separable horizontal-then-vertical Keys (a = -0.5) kernel and returns it over a valid/ready output. A pixel counter pulses `done` at the end of each N_PIX-pixel frame.

## Interface
- DATA_W, 8: pixel width, unsigned.
- FRAC_W, 4: phase precision; phase t = f / 2^FRAC_W, f in [0, 2^FRAC_W-1].
- N_PIX, 16: output pixels per frame; `done` fires after the N_PIX-th output handshake. N_PIX >= 1.
- clk  in  1  single clock; all registers on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  row beat valid.
- in_ready  out  1  engine accepts a row beat.
- in_row  in  4*DATA_W  pixels p0..p3, with p0 in the LSBs.
- in_fx, in_fy  in  FRAC_W each  horizontal/vertical phase; sampled on row-0 beat only.
- in_mode  in  2  00 bicubic, 01 bilinear, 10 nearest, 11 reserved (= bicubic); sampled on row-0 beat only.
- out_valid  out  1  out_val valid.
- out_ready  in  1  consumer accepts out_val.
- out_val  out  DATA_W  interpolated pixel.
- done  out  1  one-cycle frame-complete pulse.

## Operation
- FSM states:
  - LOAD: row counter r = 0..3. On in_valid & in_ready, compute the horizontal sum h[r] and register it; r++. The beat with r = 3 moves to CALC.
  - CALC: one cycle. Compute the vertical sum, then round and clamp into out_val. Set out_valid. Move to OUT.
  - OUT: hold until out_valid & out_ready, then go to LOAD with r = 0.
- in_ready = (state == LOAD) and rst high. in_ready is low in CALC and OUT; there is no overlap between windows.
- Integer weights: S = 2^FRAC_W, T = f, scale 2*S^3. Each weight set sums to 2*S^3.
  - Bicubic:
    - W0 = -T^3 + 2T^2*S - T*S^2
    - W1 = 3T^3 - 5T^2*S + 2S^3
    - W2 = -3T^3 + 4T^2*S + T*S^2
    - W3 = T^3 - T^2*S
  - Bilinear: W0 = W3 = 0, W1 = 2S^2*(S-T), W2 = 2S^2*T.
  - Nearest: if T < S/2 then W1 = 2S^3, else W2 = 2S^3; all other weights 0.
- h[r] = sum Wi(fx) * p_i. h is signed, kept at full precision (DATA_W + 3*FRAC_W + 3 bits), with no intermediate rounding.
- acc = sum Wj(fy) * h[j], signed, DATA_W + 6*FRAC_W + 6 bits.
- Result = (acc + 2^(K-1)) >>> K with K = 6*FRAC_W + 2 (round half up, arithmetic shift). The result is then clamped to [0, 2^DATA_W - 1].
- Frame counter cnt counts output handshakes.
  - On the handshake where cnt = N_PIX-1: done = 1 on the next cycle and cnt returns to 0.
  - Otherwise done = 0.

## Timing
- Reset (rst low, asynchronous):
  - state = LOAD, r = 0, cnt = 0.
  - out_valid = 0, out_val = 0, done = 0, in_ready = 0.
  - Registered h/phase/mode values are cleared.
- First cycle after release: in_ready = 1.
- Latency: if the row-3 beat is accepted at edge E, out_valid and out_val are registered at edge E+1.
- Minimum interval: 6 cycles per pixel (4 LOAD + CALC + OUT with out_ready held high).
- out_val is stable while out_valid = 1 and out_ready = 0. out_valid drops on the edge after the handshake.
- Gaps in in_valid during LOAD stall r; the partial window is held indefinitely.
- in_fx, in_fy and in_mode on rows 1-3 are ignored.
- A reset mid-window or mid-OUT discards the window and the pending output, and clears cnt. No done pulse is generated.
- done is registered and asserts one cycle after the final handshake, coincident with out_valid = 0.

## Test plan
- Flat window, all p = 100, fx = 5, fy = 11, bicubic -> out_val = 100; latency exactly 1 edge after the row-3 beat.
- fx = fy = 0, bicubic, row1 = {10,77,30,40}, other rows random -> out_val = 77.
- fx = fy = 8, bicubic, every row identical:
  - {0,0,255,255} -> 128 (127.5 rounds up).
  - {255,0,0,255} -> 0 (negative clamp).
  - {0,255,255,0} -> 255 (positive clamp).
- Every row {0,100,200,0}, fy = 0:
  - bilinear, fx = 4 -> 125.
  - nearest, fx = 7 -> 100.
  - nearest, fx = 8 -> 200.
  - mode 11, fx = 0 -> 100.
- Backpressure: hold out_ready low for 5 cycles -> out_val stable, in_ready = 0, in_valid beats ignored; release -> one handshake, then in_ready = 1 on the next cycle.
- N_PIX = 3, three windows -> done pulses exactly once, one cycle after the 3rd handshake. Assert rst mid-row-2 of the 4th window -> outputs at reset values, and the next 3 windows give one done pulse.
